boot_mem_loader: RTL
====================

Name: boot_mem_loader

Overview:
- Unified 256x16 program/data memory that sits directly downstream of the CPU's MAR/MBR memory port.
- Also owns CPU reset sequencing. After system reset it clears the RAM, then accepts a program as a byte stream over a valid/ready loader port and packs the bytes into 16-bit words.
- Once loading finishes it releases the CPU from reset and serves CPU reads and writes.

Parameters:
ADDR_W, 8, memory address width; depth = 2**ADDR_W words
DATA_W, 16, memory word width; must equal 2x loader byte width
CLEAR_ON_RESET, 1, 1 = zero all words after reset before LOAD; 0 = go straight to LOAD

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
cpu_addr  input  ADDR_W  CPU address (from MAR)
cpu_wdata  input  DATA_W  CPU write data (from MBR)
cpu_we  input  1  CPU write strobe (memory <- MBR control signal)
cpu_rdata  output  DATA_W  read data to MBR
cpu_rst_n  output  1  active-low reset driven to the CPU core
ld_start  input  1  single-cycle pulse: reload program
ld_valid  input  1  loader byte valid
ld_data  input  8  loader byte
ld_last  input  1  marks final byte of the image, qualified by ld_valid
ld_ready  output  1  loader may present a byte
load_done  output  1  high in RUN
overflow_err  output  1  sticky: image exceeded memory depth
word_count  output  ADDR_W+1  words written during the last/current load

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), fixed.
- States: CLEAR, LOAD, RUN.
- Reset state: CLEAR if CLEAR_ON_RESET=1, otherwise LOAD.
- Reset output values: cpu_rst_n=0, ld_ready=0, load_done=0, overflow_err=0, word_count=0; the internal pointer and byte-phase bit are cleared.
- RAM contents are not reset. Only CLEAR zeroes them.
- CLEAR:
  - Writes 0 to mem[clr_ptr], one word per cycle, for addresses 0..255.
  - Takes exactly 256 cycles, then enters LOAD.
  - ld_start is ignored in this state.
- LOAD:
  - ld_ready=1 and cpu_rst_n=0. A byte transfers when ld_valid & ld_ready.
  - Bytes are big-endian: the first byte of a pair is latched as hi.
  - The second byte writes {hi, byte} to mem[ptr] on the same edge, then ptr++ and word_count++.
  - If ld_last is accepted while phase=hi, {byte, 8'h00} is written (odd image padded).
  - On the edge that accepts ld_last: the final word is written, state becomes RUN, cpu_rst_n=1, load_done=1, ld_ready=0.
  - Zero-length image is impossible: ld_last always comes with a byte.
  - Overflow: if a word would be written with ptr==2**ADDR_W, the word is dropped and overflow_err is set (sticky until rst_n). word_count saturates at 256. The block keeps accepting bytes until ld_last.
- RUN:
  - cpu_we=1 writes cpu_wdata to mem[cpu_addr] at the rising edge.
  - ld_start=1 causes, on the next edge: state=LOAD, cpu_rst_n=0, load_done=0, ptr=0, phase=hi, word_count=0. overflow_err is kept.
  - A cpu_we in the same cycle as ld_start is still performed.
- Read path:
  - cpu_rdata = mem[cpu_addr], an asynchronous combinational read, valid in every state.
  - A read of an address written on the current edge returns the new value from the next cycle.
- Write-port priority: CLEAR writer > loader > CPU.
  - cpu_we is ignored whenever cpu_rst_n=0.
  - The CPU cannot be out of reset outside RUN, so there is no true port conflict.
- ld_start in LOAD restarts the load: ptr=0, phase=hi, word_count=0, and any pending hi byte is discarded.
  - If ld_start and an accepted byte coincide, the restart wins and the byte is dropped.
- rst_n asserted mid-LOAD or mid-CLEAR aborts immediately to the reset state. Partial contents remain until CLEAR overwrites them.
- Address wrap: ptr is ADDR_W+1 bits wide so it does not wrap; overflow is detected instead.

Decomposition:
- Shared package (cpu_pkg):
  - State enum {CLEAR, LOAD, RUN}.
  - ADDR_W / DATA_W constants, shared with MAR/MBR.
  - MEM_DEPTH.
- One sub-module: cpu_ram, a single-write-port, asynchronous-read RAM (DATA_W x 2**ADDR_W) with no reset.
- The write-port mux and the FSM stay in boot_mem_loader.

Test Plan:
- Reset, CLEAR_ON_RESET=1 -> cpu_rst_n stays 0 for 256 cycles; ld_ready rises on cycle 257; mem[0..255]=0.
- Load bytes 12,34,56,78,9A (last) -> mem[0]=1234, mem[1]=5678, mem[2]=9A00; word_count=3; cpu_rst_n=1 on the edge accepting 9A.
- RUN: cpu_we=1, addr=05, wdata=BEEF -> cpu_rdata=BEEF next cycle at addr 05. Then assert cpu_we during LOAD -> mem unchanged.
- Load 514 bytes -> overflow_err=1, word_count=256, mem[255] holds word 256; load still completes on ld_last.
- ld_start mid-LOAD after 3 bytes, then reload AA,BB (last) -> mem[0]=AABB, word_count=1; the pending hi byte is discarded.
- ld_start in RUN with ld_valid throttled (random gaps) -> cpu_rst_n=0 the next cycle; no byte is lost or duplicated, checked against a scoreboard.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU memory-system definitions.
// Holds the MAR/MBR widths used by the memory, the memory depth, the loader
// byte width and the boot-loader state encoding.
package cpu_pkg;

  // Widths shared with the CPU's MAR and MBR.
  localparam int unsigned CPU_ADDR_W = 8;
  localparam int unsigned CPU_DATA_W = 16;

  // Number of words in the unified program/data memory.
  localparam int unsigned MEM_DEPTH = 2 ** CPU_ADDR_W;

  // The loader streams bytes; two bytes make one memory word.
  localparam int unsigned LD_BYTE_W = 8;

  // Boot sequencing states.
  typedef enum logic [1:0] {
    StClear = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2
  } boot_state_e;

endpackage

// File: rtl/cpu_ram.sv
// Single-write-port, asynchronous-read RAM with no reset.
// Ports:
//   clk_i    write clock
//   we_i     write enable, written on the rising edge of clk_i
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i
module cpu_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];

  // Contents are deliberately not reset; the boot sequencer clears them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/boot_mem_loader.sv
// Unified program/data memory with CPU reset sequencing.
// After reset the memory is optionally zeroed (CLEAR), then a program is
// streamed in as big-endian byte pairs (LOAD), then the CPU is released from
// reset and owns the memory (RUN). ld_start reloads from RUN or restarts a
// load in progress.
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   cpu_addr/wdata/we  CPU memory port (from MAR/MBR), writes honoured in RUN only
//   cpu_rdata          combinational read of mem[cpu_addr], valid in all states
//   cpu_rst_n          active-low reset to the CPU core, high only in RUN
//   ld_start           reload/restart pulse (ignored during CLEAR)
//   ld_valid/data/last loader byte stream, ld_ready is its handshake
//   load_done          high in RUN
//   overflow_err       sticky: image longer than memory
//   word_count         words written by the last/current load, saturates at depth
module boot_mem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W         = CPU_ADDR_W,
  parameter int unsigned DATA_W         = CPU_DATA_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              load_done,
  output logic              overflow_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned ByteW = LD_BYTE_W;
  localparam boot_state_e ResetState = CLEAR_ON_RESET ? StClear : StLoad;
  localparam logic [ADDR_W:0] PtrOne = {{ADDR_W{1'b0}}, 1'b1};

  boot_state_e state_q, state_d;
  // One extra bit so a full image leaves ptr at depth instead of wrapping to 0.
  logic [ADDR_W:0] ptr_q, ptr_d;
  // 0: next accepted byte is the high byte of a word, 1: the low byte.
  logic            phase_q, phase_d;
  logic [ByteW-1:0] hi_q, hi_d;
  logic [ADDR_W:0] word_count_q, word_count_d;
  logic            overflow_q, overflow_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;
  logic            ld_ready_q, ld_ready_d;
  logic            load_done_q, load_done_d;

  logic              ld_accept;
  logic [DATA_W-1:0] ld_word;
  logic              clr_we;
  logic              ld_we;
  logic              cpu_we_ok;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign ld_accept = ld_valid & ld_ready_q;
  // An ld_last seen in the high phase pads the odd byte with a zero low byte.
  assign ld_word   = phase_q ? {hi_q, ld_data} : {ld_data, {ByteW{1'b0}}};
  // The CPU can only be out of reset in RUN, so its writes never collide with
  // the clear or loader writers.
  assign cpu_we_ok = cpu_we & cpu_rst_n_q;

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    clr_we       = 1'b0;
    ld_we        = 1'b0;

    unique case (state_q)
      StClear: begin
        clr_we = 1'b1;
        if (ptr_q[ADDR_W-1:0] == {ADDR_W{1'b1}}) begin
          state_d = StLoad;
          ptr_d   = '0;
          phase_d = 1'b0;
        end else begin
          ptr_d = ptr_q + PtrOne;
        end
      end

      StLoad: begin
        if (ld_start) begin
          // Restart wins over a coincident byte; a pending high byte is lost.
          ptr_d        = '0;
          phase_d      = 1'b0;
          word_count_d = '0;
        end else if (ld_accept) begin
          if (phase_q || ld_last) begin
            phase_d = 1'b0;
            if (!ptr_q[ADDR_W]) begin
              ld_we        = 1'b1;
              ptr_d        = ptr_q + PtrOne;
              word_count_d = word_count_q + PtrOne;
            end else begin
              // Memory full: drop the word but keep draining to ld_last.
              overflow_d = 1'b1;
            end
          end else begin
            hi_d    = ld_data;
            phase_d = 1'b1;
          end
          if (ld_last) begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (ld_start) begin
          state_d      = StLoad;
          ptr_d        = '0;
          phase_d      = 1'b0;
          word_count_d = '0;
        end
      end

      default: begin
        state_d = ResetState;
      end
    endcase

    // Handshake/status outputs are registered and follow the next state.
    cpu_rst_n_d = (state_d == StRun);
    load_done_d = (state_d == StRun);
    ld_ready_d  = (state_d == StLoad);
  end

  // Write-port mux: clear writer, then loader, then CPU.
  always_comb begin
    ram_we    = clr_we | ld_we | cpu_we_ok;
    ram_waddr = cpu_addr;
    ram_wdata = cpu_wdata;
    if (clr_we) begin
      ram_waddr = ptr_q[ADDR_W-1:0];
      ram_wdata = '0;
    end else if (ld_we) begin
      ram_waddr = ptr_q[ADDR_W-1:0];
      ram_wdata = ld_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ResetState;
      ptr_q        <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      ld_ready_q   <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      ld_ready_q   <= ld_ready_d;
      load_done_q  <= load_done_d;
    end
  end

  cpu_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cpu_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (cpu_addr),
    .rdata_o (cpu_rdata)
  );

  assign cpu_rst_n    = cpu_rst_n_q;
  assign ld_ready     = ld_ready_q;
  assign load_done    = load_done_q;
  assign overflow_err = overflow_q;
  assign word_count   = word_count_q;

endmodule
